// File: rtl/rsr_pkg.sv
// Shared definitions for the RAM stream reader and its output buffer.
package rsr_pkg;

    // Transfer controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest output buffer that still sustains one beat per cycle
    // across the one-cycle RAM read latency.
    localparam int FIFO_MIN_DEPTH = 2;

endpackage

// File: rtl/stream_fifo.sv
// Small registered FIFO used as the output buffer of stream blocks.
// Push while full is only legal together with a pop; the caller gates it.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_pop   = i_pop & ~o_empty;
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a contiguous block from a single-port synchronous RAM and presents
// it as a valid/ready stream. Reads are only issued when the output buffer
// is guaranteed room for the returning word, so nothing is lost or repeated.
module ram_stream_reader
    import rsr_pkg::*;
#(
    parameter int addr_width_g = 11,
    parameter int data_width_g = 8,
    parameter int fifo_depth_g = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [addr_width_g-1:0] base_addr,
    input  logic [addr_width_g-1:0] len_m1,
    output logic                    busy,
    output logic                    done,
    output logic [addr_width_g-1:0] ram_address,
    output logic                    ram_wren,
    input  logic [data_width_g-1:0] ram_q,
    output logic [data_width_g-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int AW      = addr_width_g;
    localparam int RW      = addr_width_g + 1;
    localparam int DEPTH_C = (fifo_depth_g < FIFO_MIN_DEPTH) ? FIFO_MIN_DEPTH : fifo_depth_g;
    localparam int CW      = $clog2(DEPTH_C + 1);

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [AW-1:0]   r_addr;
    logic [RW-1:0]   r_issue_rem;
    logic [RW-1:0]   r_beat_rem;
    logic            r_inflight;

    logic [RW-1:0]   w_len;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CW:0]     w_occ;
    logic [CW:0]     w_lim;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;

    // Transfer length in words; len_m1 at its maximum needs the extra bit.
    assign w_len = {1'b0, len_m1} + {{AW{1'b0}}, 1'b1};

    assign w_pop  = out_valid & out_ready;
    // Issue rule already prevents overflow; the guard keeps the buffer safe regardless.
    assign w_push = r_inflight & (~w_full | w_pop);

    // Issue a read only if the buffer will have room once the word returns.
    always_comb begin
        w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
        w_lim   = (CW + 1)'(DEPTH_C) + {{CW{1'b0}}, w_pop};
        w_issue = (r_state == RUN) && (r_issue_rem != '0) && (w_occ < w_lim);
    end

    stream_fifo #(
        .WIDTH (data_width_g),
        .DEPTH (DEPTH_C)
    ) u_fifo (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_push      (w_push),
        .i_push_data (ram_q),
        .i_pop       (w_pop),
        .o_head      (out_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Transfer FSM with address/issue/beat counters and registered status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_issue_rem <= '0;
            r_beat_rem  <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_addr      <= base_addr;
                        r_issue_rem <= w_len;
                        r_beat_rem  <= w_len;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + 1'b1;
                        r_issue_rem <= r_issue_rem - 1'b1;
                    end
                    if (w_pop) begin
                        r_beat_rem <= r_beat_rem - 1'b1;
                        if (r_beat_rem == RW'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign ram_address = r_addr;
    assign ram_wren    = 1'b0;
    assign out_valid   = ~w_empty;
    assign out_last    = ~w_empty & (r_beat_rem == RW'(1));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a registered-read RAM model.
module tb_ram_stream_reader;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int FD = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len_m1;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [DW-1:0] mem [2**AW];

    int n_checks = 0;
    int n_fail   = 0;

    ram_stream_reader #(
        .addr_width_g (AW),
        .data_width_g (DW),
        .fifo_depth_g (FD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .len_m1      (len_m1),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    always #5 clock = ~clock;

    // RAM model: one-cycle registered read, contents = low address byte.
    always @(posedge clock) begin
        ram_q <= mem[ram_address];
    end

    initial begin
        for (int a = 0; a < 2**AW; a++) begin
            mem[a] = 8'(a);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Holds start for one cycle; returns at the first cycle of RUN.
    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        base_addr = b;
        len_m1    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; len_m1 = '0;
        tick(); tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
        n_checks++; if (ram_address !== 11'h000) begin n_fail++; $display("FAIL reset_addr: got %h want 000", ram_address); end
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", ram_wren); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d;
        out_ready = 1'b1;
        pulse_start(11'h010, 11'd3);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_T1: got %b want 1", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_T1: got %b want 0", out_valid); end
        n_checks++; if (ram_address !== 11'h010) begin n_fail++; $display("FAIL basic_addr_T1: got %h want 010", ram_address); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_T2: got %b want 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_d = 8'(16 + i);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid beat %0d: got %b want 1", i, out_valid); end
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL basic_data beat %0d: got %h want %h", i, out_data, exp_d); end
            n_checks++; if (out_last !== (i == 3)) begin n_fail++; $display("FAIL basic_last beat %0d: got %b want %b", i, out_last, (i == 3)); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done beat %0d: got %b want 0", i, done); end
        end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_at_done: got %b want 0", out_valid); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        int            beats = 0;
        int            dones = 0;
        int            issued;
        logic          rdy;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] exp_d;
        out_ready = 1'b0;
        pulse_start(11'h010, 11'd3);
        for (int k = 0; k < 30; k++) begin
            rdy = (k % 3 == 0);
            if (done === 1'b1) dones++;
            if (prev_stall) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid k=%0d: got %b want 1", k, out_valid); end
                n_checks++; if (out_data !== prev_data) begin n_fail++; $display("FAIL bp_stall_data k=%0d: got %h want %h", k, out_data, prev_data); end
            end
            if (busy === 1'b1) begin
                issued = int'(11'(ram_address - 11'h010));
                n_checks++; if (issued - beats > FD) begin n_fail++; $display("FAIL bp_read_ahead k=%0d: got %0d want <= %0d", k, issued - beats, FD); end
            end
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                exp_d = 8'(16 + beats);
                n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL bp_data beat %0d: got %h want %h", beats, out_data, exp_d); end
                n_checks++; if (out_last !== (beats == 3)) begin n_fail++; $display("FAIL bp_last beat %0d: got %b want %b", beats, out_last, (beats == 3)); end
                beats++;
            end
            prev_stall = (out_valid === 1'b1) && !rdy;
            prev_data  = out_data;
            tick();
        end
        out_ready = 1'b0;
        n_checks++; if (beats != 4) begin n_fail++; $display("FAIL bp_beat_count: got %0d want 4", beats); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", dones); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        logic [AW-1:0] a;
        exp_a[0] = 11'h7FE; exp_a[1] = 11'h7FF; exp_a[2] = 11'h000; exp_a[3] = 11'h001;
        out_ready = 1'b1;
        pulse_start(11'h7FE, 11'd3);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) begin
                n_checks++; if (ram_address !== exp_a[k-1]) begin n_fail++; $display("FAIL wrap_addr k=%0d: got %h want %h", k, ram_address, exp_a[k-1]); end
            end
            if (k >= 3) begin
                a = exp_a[k-3];
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid k=%0d: got %b want 1", k, out_valid); end
                n_checks++; if (out_data !== a[7:0]) begin n_fail++; $display("FAIL wrap_data k=%0d: got %h want %h", k, out_data, a[7:0]); end
                n_checks++; if (out_last !== (k == 6)) begin n_fail++; $display("FAIL wrap_last k=%0d: got %b want %b", k, out_last, (k == 6)); end
            end
            tick();
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_ignore_start();
        int            dones = 0;
        logic [DW-1:0] exp_d;
        out_ready = 1'b1;
        pulse_start(11'h040, 11'd3);
        base_addr = 11'h100;
        len_m1    = 11'd7;
        start     = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) start = 1'b0;
            if (done === 1'b1) dones++;
            if (k >= 3 && k <= 6) begin
                exp_d = 8'(64 + k - 3);
                n_checks++; if (out_data !== exp_d || out_valid !== 1'b1) begin n_fail++; $display("FAIL ign_data k=%0d: got %h/%b want %h/1", k, out_data, out_valid, exp_d); end
                n_checks++; if (out_last !== (k == 6)) begin n_fail++; $display("FAIL ign_last k=%0d: got %b want %b", k, out_last, (k == 6)); end
            end
            if (k == 7) begin
                n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %b want 1", done); end
            end
            tick();
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", dones); end
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_idle_end: got busy=%b valid=%b want 0/0", busy, out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        pulse_start(11'h050, 11'd7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
        n_checks++; if (ram_address !== 11'h000) begin n_fail++; $display("FAIL rmid_addr: got %h want 000", ram_address); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet k=%0d: got done=%b valid=%b want 0/0", k, done, out_valid); end
        end
        out_ready = 1'b1;
        pulse_start(11'h020, 11'd0);
        tick(); tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h20) begin n_fail++; $display("FAIL rmid_beat: got %b/%h want 1/20", out_valid, out_data); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL rmid_last: got %b want 1", out_last); end
        tick();
        n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_done_after: got done=%b valid=%b want 1/0", done, out_valid); end
        tick();
    endtask

    task automatic test_single_stall();
        out_ready = 1'b0;
        pulse_start(11'h005, 11'd0);
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL ss_wren_run: got %b want 0", ram_wren); end
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin n_fail++; $display("FAIL ss_hold cyc %0d: got valid=%b last=%b want 1/1", i, out_valid, out_last); end
            n_checks++; if (out_data !== 8'h05) begin n_fail++; $display("FAIL ss_data cyc %0d: got %h want 05", i, out_data); end
            n_checks++; if (done !== 1'b0 || ram_wren !== 1'b0) begin n_fail++; $display("FAIL ss_done_wren cyc %0d: got done=%b wren=%b want 0/0", i, done, ram_wren); end
            tick();
        end
        out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ss_valid_release: got %b want 1", out_valid); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ss_done: got done=%b busy=%b want 1/0", done, busy); end
        n_checks++; if (out_valid !== 1'b0 || ram_wren !== 1'b0) begin n_fail++; $display("FAIL ss_after: got valid=%b wren=%b want 0/0", out_valid, ram_wren); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ss_done_width: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_ignore_start();
        test_reset_mid();
        test_single_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
